// File: rtl/lsexec_if.sv
// lsexec_if: load/store issue handshake plus CDB request/grant port.
//   equeuels_* : operation fields and ready from the issue queue, done back to it
//   cdb_*      : load result request/data/tag to the arbiter, grant back from it
//   modport master : issue queue / arbiter side
//   modport slave  : execution unit side
interface lsexec_if #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 32
);
    logic              equeuels_opcode;
    logic [5:0]        equeuels_rdtag;
    logic [W_ADDR-1:0] equeuels_addr;
    logic [W_DATA-1:0] equeuels_data;
    logic              equeuels_ready;
    logic              equeuels_done;
    logic              cdb_req;
    logic              cdb_grant;
    logic [W_DATA-1:0] cdb_data;
    logic [5:0]        cdb_tag;
    modport master (
        output equeuels_opcode, equeuels_rdtag, equeuels_addr, equeuels_data, equeuels_ready, cdb_grant,
        input  equeuels_done, cdb_req, cdb_data, cdb_tag
    );
    modport slave (
        input  equeuels_opcode, equeuels_rdtag, equeuels_addr, equeuels_data, equeuels_ready, cdb_grant,
        output equeuels_done, cdb_req, cdb_data, cdb_tag
    );
endinterface

// File: rtl/lsexec.sv
// lsexec: load/store execution unit with a private word-addressed memory of fixed latency.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : lsexec_if.slave (issue handshake in, CDB request/grant out)
//   Optional LSEXEC_STORE_ACK_EN: stores also raise cdb_req with their rdtag and zero data.
module lsexec #(
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    lsexec_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
`ifdef LSEXEC_STORE_ACK_EN
    localparam bit STORE_ACK = 1'b1;
`else
    localparam bit STORE_ACK = 1'b0;
`endif
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_q;
    logic [5:0]            tag_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [W_DATA-1:0]     data_q;
    logic                  done_q;
    logic [W_DATA-1:0]     cdb_data_q;
    logic [5:0]            cdb_tag_q;
    logic [W_DATA-1:0]     mem [2**DEPTH_LOG2];
    logic                  accept, last;
    logic                  unused_addr;
    // Byte offset and bits above the memory size are dropped, so addresses wrap.
    assign unused_addr = ^{bus.equeuels_addr[W_ADDR-1:DEPTH_LOG2+2], bus.equeuels_addr[1:0]};
    assign accept = state_q == IDLE && bus.equeuels_ready;
    assign last   = state_q == ACCESS && cnt_q == 4'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ACCESS;
            cnt_d   = LAT_M1;
        end else if (state_q == ACCESS) begin
            cnt_d   = last ? cnt_q : cnt_q - 4'd1;
            state_d = last ? ((op_q || STORE_ACK) ? RESP : IDLE) : ACCESS;
        end else if (state_q == RESP && bus.cdb_grant) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            tag_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            cdb_data_q <= '0;
            cdb_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= accept;
            if (accept) begin
                op_q   <= bus.equeuels_opcode;
                tag_q  <= bus.equeuels_rdtag;
                idx_q  <= bus.equeuels_addr[DEPTH_LOG2+1:2];
                data_q <= bus.equeuels_data;
            end
            if (last && state_d == RESP) begin
                cdb_data_q <= op_q ? mem[idx_q] : '0;
                cdb_tag_q  <= tag_q;
            end
        end
    end
    // Memory is not reset, but a reset on the final access edge blocks the write.
    always_ff @(posedge clk) begin
        if (reset && last && !op_q) mem[idx_q] <= data_q;
    end
    assign bus.equeuels_done = done_q;
    assign bus.cdb_req       = state_q == RESP;
    assign bus.cdb_data      = cdb_data_q;
    assign bus.cdb_tag       = cdb_tag_q;
endmodule

// File: tb/tb_lsexec.sv
// tb_lsexec: directed self-checking bench for lsexec (MEM_LATENCY=2, DEPTH_LOG2=8).
module tb_lsexec;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] held_data;
    logic [5:0]  held_tag;
    lsexec_if #(.W_DATA(32), .W_ADDR(32)) bus ();
    lsexec #(.W_DATA(32), .W_ADDR(32), .DEPTH_LOG2(8), .MEM_LATENCY(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask
    task automatic chk_out(input string name, input logic done, input logic req, input logic [31:0] data, input logic [5:0] tag);
        chk({name, "_done"}, 32'(bus.equeuels_done), 32'(done));
        chk({name, "_req"}, 32'(bus.cdb_req), 32'(req));
        chk({name, "_data"}, bus.cdb_data, data);
        chk({name, "_tag"}, 32'(bus.cdb_tag), 32'(tag));
    endtask
    // Presents one operation for a single capture edge; returns in cycle 1 with done checked.
    task automatic issue(input logic op, input logic [5:0] tag, input logic [31:0] addr, input logic [31:0] data);
        bus.equeuels_opcode = op;
        bus.equeuels_rdtag  = tag;
        bus.equeuels_addr   = addr;
        bus.equeuels_data   = data;
        bus.equeuels_ready  = 1'b1;
        tick();
        bus.equeuels_ready  = 1'b0;
        chk("issue_done", 32'(bus.equeuels_done), 32'd1);
        chk("issue_req", 32'(bus.cdb_req), 32'd0);
    endtask
    initial begin
        bus.equeuels_opcode = 1'b1;
        bus.equeuels_rdtag  = 6'h3f;
        bus.equeuels_addr   = 32'h10;
        bus.equeuels_data   = 32'h0;
        bus.equeuels_ready  = 1'b1;
        bus.cdb_grant       = 1'b1;
        // Reset held low for two cycles while ready is asserted.
        tick();
        chk_out("rst0", 1'b0, 1'b0, 32'h0, 6'h0);
        tick();
        chk_out("rst1", 1'b0, 1'b0, 32'h0, 6'h0);
        bus.equeuels_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk_out("idle", 1'b0, 1'b0, 32'h0, 6'h0);
        // Store then load with grant tied high.
        issue(1'b0, 6'h00, 32'h10, 32'h12345678);
        tick();
        chk_out("st_c2", 1'b0, 1'b0, 32'h0, 6'h0);
        tick();
        issue(1'b1, 6'h05, 32'h10, 32'h0);
        tick();
        chk_out("ld_c2", 1'b0, 1'b0, 32'h0, 6'h0);
        tick();
        chk_out("ld_c3", 1'b0, 1'b1, 32'h12345678, 6'h05);
        tick();
        chk_out("ld_c4", 1'b0, 1'b0, 32'h12345678, 6'h05);
        // Withheld grant with ready stuck high.
        bus.cdb_grant = 1'b0;
        issue(1'b1, 6'h21, 32'h10, 32'h0);
        bus.equeuels_ready = 1'b1;
        tick();
        tick();
        chk_out("hold_c3", 1'b0, 1'b1, 32'h12345678, 6'h21);
        held_data = bus.cdb_data;
        held_tag  = bus.cdb_tag;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("hold", 1'b0, 1'b1, 32'h12345678, 6'h21);
        end
        bus.cdb_grant = 1'b1;
        bus.equeuels_ready = 1'b0;
        tick();
        chk_out("hold_rel", 1'b0, 1'b0, held_data, held_tag);
        tick();
        chk_out("hold_idle", 1'b0, 1'b0, held_data, held_tag);
        // Unaligned, out-of-range store wraps onto word 0.
        issue(1'b0, 6'h00, 32'h00000403, 32'hCAFEF00D);
        tick();
        tick();
        issue(1'b1, 6'h01, 32'h00000000, 32'h0);
        tick();
        tick();
        chk_out("wrap", 1'b0, 1'b1, 32'hCAFEF00D, 6'h01);
        tick();
        // Reset on the final access edge of a store suppresses the write.
        issue(1'b0, 6'h00, 32'h20, 32'h55555555);
        tick();
        tick();
        issue(1'b0, 6'h00, 32'h20, 32'hAAAAAAAA);
        tick();
        reset = 1'b0;
        tick();
        chk_out("rst_st", 1'b0, 1'b0, 32'h0, 6'h0);
        reset = 1'b1;
        tick();
        issue(1'b1, 6'h07, 32'h20, 32'h0);
        tick();
        tick();
        chk_out("rst_st_ld", 1'b0, 1'b1, 32'h55555555, 6'h07);
        tick();
        // Store acknowledge on the CDB depends on the build option.
        bus.cdb_grant = 1'b0;
        issue(1'b0, 6'h0A, 32'h30, 32'h77);
        tick();
        tick();
`ifdef LSEXEC_STORE_ACK_EN
        chk_out("st_ack", 1'b0, 1'b1, 32'h0, 6'h0A);
`else
        chk_out("st_ack", 1'b0, 1'b0, 32'h55555555, 6'h07);
`endif
        bus.cdb_grant = 1'b1;
        tick();
        chk("st_ack_rel_req", 32'(bus.cdb_req), 32'd0);
        // Reset in RESP drops the pending result.
        bus.cdb_grant = 1'b0;
        issue(1'b1, 6'h12, 32'h30, 32'h0);
        tick();
        tick();
        chk_out("resp_pre", 1'b0, 1'b1, 32'h77, 6'h12);
        reset = 1'b0;
        tick();
        chk_out("resp_rst", 1'b0, 1'b0, 32'h0, 6'h0);
        reset = 1'b1;
        tick();
        chk_out("resp_idle", 1'b0, 1'b0, 32'h0, 6'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
